icache_responder: RTL and testbench

- Instruction-cache responder: the cache-side end of the datapath instruction-fetch interface.
- Serves imemREN/imemaddr requests from the pipelined datapath with ihit/imemload.
- On a miss, issues a two-word block fill to the memory controller over the iREN/iaddr/iwait/iload memory interface.
- Organisation: direct-mapped, 2-word blocks, read-only (no write-back, no coherence).

---
 rtl/icache_responder.sv | 151 +++++++++++++++
 tb/tb_icache_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_responder.sv
// ---------------------------------------------------------------------------
// icache_responder
// Cache-side end of the datapath instruction-fetch interface. Direct-mapped,
// 2-word blocks, read-only. Resident words are returned combinationally.
// A miss triggers a two-beat block fill from the memory controller.
//
// Ports
//   CLK       in   clock, all state updates on posedge
//   nRST      in   synchronous active-low reset
//   imemREN   in   datapath fetch request
//   imemaddr  in   fetch byte address ([2] word, [2+IDXW:3] index, rest tag)
//   ihit      out  requested word valid on imemload this cycle
//   imemload  out  fetched instruction (0 when not hitting)
//   iREN      out  memory read request
//   iaddr     out  memory word address ([1:0] always 0)
//   iwait     in   memory busy; a beat is accepted when iREN=1 and iwait=0
//   iload     in   memory read data
// ---------------------------------------------------------------------------
module icache_responder #(
    parameter int SETS = 16,
    parameter int TAGW = 32 - 3 - $clog2(SETS)
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int IDXW = $clog2(SETS);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FETCH0 = 2'b01,
        FETCH1 = 2'b10
    } state_t;

    state_t              state_q;
    logic [SETS-1:0]     valid_q;
    logic [TAGW-1:0]     tag_q   [SETS];
    logic [31:0]         word0_q [SETS];
    logic [31:0]         word1_q [SETS];
    logic [TAGW-1:0]     miss_tag_q;
    logic [IDXW-1:0]     miss_idx_q;
    logic [31:0]         fill_buf_q;
    logic                iren_q;
    logic [31:0]         iaddr_q;

    logic [TAGW-1:0]     addr_tag_s;
    logic [IDXW-1:0]     addr_idx_s;
    logic                hit_s;
    logic                fill_we_s;
    logic                unused_s;

    assign addr_tag_s = imemaddr[31:3+IDXW];
    assign addr_idx_s = imemaddr[2+IDXW:3];
    assign unused_s   = ^imemaddr[1:0];

    // Lookups are only honoured in IDLE so a fill in flight hides the array.
    assign hit_s = (state_q == IDLE) & imemREN & valid_q[addr_idx_s]
                 & (tag_q[addr_idx_s] == addr_tag_s);

    // Final beat accepted: the whole block lands in one edge, never partially.
    assign fill_we_s = nRST & (state_q == FETCH1) & ~iwait;

    // Hit-path outputs; forced quiet while reset is held.
    always_comb begin
        ihit     = 1'b0;
        imemload = 32'h0000_0000;
        if (nRST && hit_s) begin
            ihit     = 1'b1;
            imemload = imemaddr[2] ? word1_q[addr_idx_s] : word0_q[addr_idx_s];
        end else begin
            ihit     = 1'b0;
            imemload = 32'h0000_0000;
        end
    end

    // Memory-side outputs come from registers; masked while reset is held.
    always_comb begin
        iREN  = 1'b0;
        iaddr = 32'h0000_0000;
        if (nRST) begin
            iREN  = iren_q;
            iaddr = iaddr_q;
        end else begin
            iREN  = 1'b0;
            iaddr = 32'h0000_0000;
        end
    end

    // Tag/data arrays: written only on the final fill beat, no reset needed.
    always_ff @(posedge CLK) begin
        if (fill_we_s) begin
            tag_q[miss_idx_q]   <= miss_tag_q;
            word0_q[miss_idx_q] <= fill_buf_q;
            word1_q[miss_idx_q] <= iload;
        end
    end

    // Fill FSM with registered memory request, valid bits and fill buffer.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q    <= IDLE;
            valid_q    <= {SETS{1'b0}};
            miss_tag_q <= {TAGW{1'b0}};
            miss_idx_q <= {IDXW{1'b0}};
            fill_buf_q <= 32'h0000_0000;
            iren_q     <= 1'b0;
            iaddr_q    <= 32'h0000_0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (imemREN && !hit_s) begin
                        miss_tag_q <= addr_tag_s;
                        miss_idx_q <= addr_idx_s;
                        iren_q     <= 1'b1;
                        iaddr_q    <= {addr_tag_s, addr_idx_s, 3'b000};
                        state_q    <= FETCH0;
                    end
                end
                FETCH0: begin
                    if (!iwait) begin
                        fill_buf_q <= iload;
                        iaddr_q    <= {miss_tag_q, miss_idx_q, 3'b100};
                        state_q    <= FETCH1;
                    end
                end
                FETCH1: begin
                    if (!iwait) begin
                        valid_q[miss_idx_q] <= 1'b1;
                        iren_q              <= 1'b0;
                        iaddr_q             <= 32'h0000_0000;
                        state_q             <= IDLE;
                    end
                end
                default: begin
                    iren_q  <= 1'b0;
                    iaddr_q <= 32'h0000_0000;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// ---------------------------------------------------------------------------
// tb_icache_responder
// Directed bench for icache_responder. Inputs change 1 time unit after each
// rising edge; outputs are checked 1 time unit later, well away from the edge.
// The memory model returns a fixed value per address and garbage whenever
// iwait is high, so a beat taken on a wait cycle shows up as bad data.
// ---------------------------------------------------------------------------
module tb_icache_responder;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int n_cmp;
    int n_bad;

    icache_responder dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h1111_1111;
            32'h0000_0004: mem_word = 32'h2222_2222;
            32'h0000_0080: mem_word = 32'hAAAA_0000;
            32'h0000_0084: mem_word = 32'hAAAA_0004;
            default:       mem_word = a ^ 32'h5A5A_0000;
        endcase
    endfunction

    always_comb begin
        iload = iwait ? 32'hDEAD_BEEF : mem_word(iaddr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        nRST     = 1'b0;
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0000;
        iwait    = 1'b0;

        // Reset held
        cyc();
        cyc();
        settle();
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_iren", {31'd0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_load", imemload, 32'h0);

        // Cold miss on 0x4
        nRST     = 1'b1;
        imemaddr = 32'h0000_0004;
        settle();
        chk("cold_c0_ihit", {31'd0, ihit}, 32'd0);
        chk("cold_c0_iren", {31'd0, iREN}, 32'd0);
        cyc();
        settle();
        chk("cold_c1_iren", {31'd0, iREN}, 32'd1);
        chk("cold_c1_iaddr", iaddr, 32'h0000_0000);
        chk("cold_c1_ihit", {31'd0, ihit}, 32'd0);
        cyc();
        settle();
        chk("cold_c2_iren", {31'd0, iREN}, 32'd1);
        chk("cold_c2_iaddr", iaddr, 32'h0000_0004);
        cyc();
        settle();
        chk("cold_c3_iren", {31'd0, iREN}, 32'd0);
        chk("cold_c3_ihit", {31'd0, ihit}, 32'd1);
        chk("cold_c3_load", imemload, 32'h2222_2222);

        // Spatial hit on word 0 of the same block
        imemaddr = 32'h0000_0000;
        settle();
        chk("spat_ihit", {31'd0, ihit}, 32'd1);
        chk("spat_load", imemload, 32'h1111_1111);
        chk("spat_iren", {31'd0, iREN}, 32'd0);

        // Conflict: 0x80 shares index 0 with tag 1
        imemaddr = 32'h0000_0080;
        settle();
        chk("conf_c0_ihit", {31'd0, ihit}, 32'd0);
        cyc();
        settle();
        chk("conf_c1_iaddr", iaddr, 32'h0000_0080);
        cyc();
        settle();
        chk("conf_c2_iaddr", iaddr, 32'h0000_0084);
        cyc();
        settle();
        chk("conf_c3_ihit", {31'd0, ihit}, 32'd1);
        chk("conf_c3_load", imemload, 32'hAAAA_0000);
        imemaddr = 32'h0000_0000;
        settle();
        chk("evict_ihit", {31'd0, ihit}, 32'd0);
        cyc();
        settle();
        chk("evict_iren", {31'd0, iREN}, 32'd1);
        chk("evict_iaddr", iaddr, 32'h0000_0000);
        cyc();
        cyc();
        settle();
        chk("evict_refill", imemload, 32'h1111_1111);

        // Wait states: 3 wait cycles before each beat, miss on 0x2C
        imemaddr = 32'h0000_002C;
        iwait    = 1'b1;
        settle();
        chk("wait_c0_ihit", {31'd0, ihit}, 32'd0);
        for (int c = 1; c <= 8; c++) begin
            cyc();
            iwait = (c == 4 || c == 8) ? 1'b0 : 1'b1;
            settle();
            chk($sformatf("wait_c%0d_iaddr", c), iaddr, (c <= 4) ? 32'h0000_0028 : 32'h0000_002C);
            chk($sformatf("wait_c%0d_iren", c), {31'd0, iREN}, 32'd1);
            chk($sformatf("wait_c%0d_ihit", c), {31'd0, ihit}, 32'd0);
        end
        cyc();
        settle();
        chk("wait_c9_ihit", {31'd0, ihit}, 32'd1);
        chk("wait_c9_load", imemload, 32'h5A5A_002C);
        chk("wait_c9_iren", {31'd0, iREN}, 32'd0);
        imemaddr = 32'h0000_0028;
        settle();
        chk("wait_w0_load", imemload, 32'h5A5A_0028);

        // Address change mid-fill: miss on 0x10, switch away during fill
        imemaddr = 32'h0000_0010;
        settle();
        chk("mid_c0_ihit", {31'd0, ihit}, 32'd0);
        cyc();
        imemaddr = 32'h0000_0040;
        settle();
        chk("mid_c1_iaddr", iaddr, 32'h0000_0010);
        chk("mid_c1_ihit", {31'd0, ihit}, 32'd0);
        cyc();
        imemaddr = 32'h0000_0000;
        settle();
        chk("mid_c2_iaddr", iaddr, 32'h0000_0014);
        chk("mid_c2_hitblk", {31'd0, ihit}, 32'd0);
        imemaddr = 32'h0000_0040;
        cyc();
        settle();
        chk("mid_c3_ihit", {31'd0, ihit}, 32'd0);
        chk("mid_c3_iren", {31'd0, iREN}, 32'd0);
        cyc();
        settle();
        chk("mid_new_iren", {31'd0, iREN}, 32'd1);
        chk("mid_new_iaddr", iaddr, 32'h0000_0040);
        cyc();
        cyc();
        settle();
        chk("mid_new_load", imemload, 32'h5A5A_0040);
        imemaddr = 32'h0000_0014;
        settle();
        chk("mid_set2_ihit", {31'd0, ihit}, 32'd1);
        chk("mid_set2_load", imemload, 32'h5A5A_0014);

        // Address wrap: last word of the address space
        imemaddr = 32'hFFFF_FFFC;
        settle();
        chk("wrap_c0_ihit", {31'd0, ihit}, 32'd0);
        cyc();
        settle();
        chk("wrap_c1_iaddr", iaddr, 32'hFFFF_FFF8);
        cyc();
        settle();
        chk("wrap_c2_iaddr", iaddr, 32'hFFFF_FFFC);
        cyc();
        settle();
        chk("wrap_c3_load", imemload, 32'hA5A5_FFFC);

        // Reset during FETCH1
        imemaddr = 32'h0000_0030;
        settle();
        cyc();
        cyc();
        settle();
        chk("rmid_c2_iaddr", iaddr, 32'h0000_0034);
        nRST = 1'b0;
        settle();
        chk("rmid_low_iren", {31'd0, iREN}, 32'd0);
        cyc();
        settle();
        chk("rmid_after_iren", {31'd0, iREN}, 32'd0);
        chk("rmid_after_iaddr", iaddr, 32'h0);
        nRST = 1'b1;
        settle();
        chk("rmid_rereq_ihit", {31'd0, ihit}, 32'd0);
        chk("rmid_rereq_iren", {31'd0, iREN}, 32'd0);
        imemaddr = 32'h0000_0000;
        settle();
        chk("rmid_valid_clr", {31'd0, ihit}, 32'd0);
        imemaddr = 32'h0000_0030;
        cyc();
        settle();
        chk("rmid_refetch_iren", {31'd0, iREN}, 32'd1);
        chk("rmid_refetch_iaddr", iaddr, 32'h0000_0030);
        cyc();
        cyc();
        settle();
        chk("rmid_final_load", imemload, 32'h5A5A_0030);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
